// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between NUM_REQ requesters, result held in a
// single-entry output slot tagged with the requester ID. Optional grant lock: ALU_ARB_LOCK_EN.
package alu_arbiter_pkg;
  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;
endpackage

module alu
  import alu_arbiter_pkg::*;
(
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags
);
  localparam int unsigned SHW = $clog2(XLEN);

  logic            is_sub;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;
  logic            carry;
  logic            overflow;

  always_comb begin
    is_sub   = (op == ALU_SUB);
    b_eff    = is_sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
    carry    = 1'b0;
    overflow = 1'b0;
    result   = '0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        result   = sum[XLEN-1:0];
        // SUB reports borrow (a < b unsigned), i.e. the inverted adder carry-out
        carry    = sum[XLEN] ^ is_sub;
        overflow = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[SHW-1:0];
      ALU_SRL:  result = a >> b[SHW-1:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[SHW-1:0]);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
    flags = {(result == '0), result[XLEN-1], carry, overflow};
  end
endmodule

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*$bits(alu_op_e)-1:0] req_op,
  input  logic [NUM_REQ*XLEN-1:0]           req_a,
  input  logic [NUM_REQ*XLEN-1:0]           req_b,
  input  logic [NUM_REQ-1:0]                req_lock,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [IDW-1:0]                    resp_id,
  output logic [XLEN-1:0]                   resp_result,
  output logic [3:0]                        resp_flags
);
  localparam int unsigned OPW = $bits(alu_op_e);

  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [XLEN-1:0] resp_result_q, resp_result_d;
  logic [3:0]      resp_flags_q, resp_flags_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            slot_free;
  logic            grant_found;
  logic            accept;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  grant_nxt;
  logic [IDW-1:0]  cand_id;
  int unsigned     cand;

  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic [3:0]      alu_flags;

`ifdef ALU_ARB_LOCK_EN
  logic            locked_q, locked_d;
  logic [IDW-1:0]  owner_q, owner_d;
`else
  logic            unused_lock;
  assign unused_lock = ^req_lock;
`endif

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_id     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_id = IDW'(cand);
      if (!grant_found && req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_idx   = cand_id;
      end
    end
`ifdef ALU_ARB_LOCK_EN
    if (locked_q) begin
      grant_found = req_valid[owner_q];
      grant_idx   = owner_q;
    end
`endif

    slot_free = !resp_valid_q || resp_ready;
    accept    = grant_found && slot_free;
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    grant_nxt = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

    alu_op = alu_op_e'(req_op[grant_idx*OPW +: OPW]);
    alu_a  = req_a[grant_idx*XLEN +: XLEN];
    alu_b  = req_b[grant_idx*XLEN +: XLEN];
  end

  alu u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    rr_ptr_d      = rr_ptr_q;
    if (accept) begin
      resp_valid_d  = 1'b1;
      resp_id_d     = grant_idx;
      resp_result_d = alu_result;
      resp_flags_d  = alu_flags;
      rr_ptr_d      = grant_nxt;
    end else if (resp_ready) begin
      resp_valid_d  = 1'b0;
    end
`ifdef ALU_ARB_LOCK_EN
    locked_d = locked_q;
    owner_d  = owner_q;
    if (accept) begin
      if (req_lock[grant_idx]) begin
        locked_d = 1'b1;
        owner_d  = grant_idx;
        rr_ptr_d = rr_ptr_q;
      end else begin
        locked_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      rr_ptr_q      <= '0;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

`ifdef ALU_ARB_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
    end
  end
`endif

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a 2-requester and a 4-requester instance checked every
// cycle against a behavioural arbitration/ALU model, plus directed scenarios and a random phase.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  v_valid [2];
  logic [7:0]  v_lock  [2];
  logic [3:0]  v_op    [2][8];
  logic [31:0] v_a     [2][8];
  logic [31:0] v_b     [2][8];
  logic        cons_ready [2];

  logic [1:0]   valid2, lock2, rdy2;
  logic [7:0]   op2;
  logic [63:0]  a2, b2;
  logic         rv2;
  logic [0:0]   id2;
  logic [31:0]  res2;
  logic [3:0]   fl2;
  logic [3:0]   valid4, lock4, rdy4;
  logic [15:0]  op4;
  logic [127:0] a4, b4;
  logic         rv4;
  logic [1:0]   id4;
  logic [31:0]  res4;
  logic [3:0]   fl4;

  always_comb begin
    valid2 = v_valid[0][1:0];
    lock2  = v_lock[0][1:0];
    valid4 = v_valid[1][3:0];
    lock4  = v_lock[1][3:0];
    for (int i = 0; i < 2; i++) begin
      op2[i*4 +: 4]  = v_op[0][i];
      a2[i*32 +: 32] = v_a[0][i];
      b2[i*32 +: 32] = v_b[0][i];
    end
    for (int i = 0; i < 4; i++) begin
      op4[i*4 +: 4]  = v_op[1][i];
      a4[i*32 +: 32] = v_a[1][i];
      b4[i*32 +: 32] = v_b[1][i];
    end
  end

  alu_arbiter #(.NUM_REQ(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(valid2), .req_ready(rdy2), .req_op(op2),
    .req_a(a2), .req_b(b2), .req_lock(lock2), .resp_valid(rv2), .resp_ready(cons_ready[0]),
    .resp_id(id2), .resp_result(res2), .resp_flags(fl2)
  );

  alu_arbiter #(.NUM_REQ(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(valid4), .req_ready(rdy4), .req_op(op4),
    .req_a(a4), .req_b(b4), .req_lock(lock4), .resp_valid(rv4), .resp_ready(cons_ready[1]),
    .resp_id(id4), .resp_result(res4), .resp_flags(fl4)
  );

  // behavioural model state, one slot per instance
  logic        m_valid  [2];
  int          m_id     [2];
  logic [31:0] m_res    [2];
  logic [3:0]  m_fl     [2];
  int          m_rr     [2];
  logic        m_locked [2];
  int          m_owner  [2];
  int          acc_g    [2];
  int          obs_ids  [$];
  int          exp_seq  [$];
  int          n_assert;
  int          n_fail;
  int          cnt0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  function automatic int nreq(input int u);
    return (u == 0) ? 2 : 4;
  endfunction

  function automatic logic [7:0] get_rdy(input int u);
    return (u == 0) ? {6'b0, rdy2} : {4'b0, rdy4};
  endfunction
  function automatic logic get_rv(input int u);
    return (u == 0) ? rv2 : rv4;
  endfunction
  function automatic logic [7:0] get_id(input int u);
    return (u == 0) ? {7'b0, id2} : {6'b0, id4};
  endfunction
  function automatic logic [31:0] get_res(input int u);
    return (u == 0) ? res2 : res4;
  endfunction
  function automatic logic [3:0] get_fl(input int u);
    return (u == 0) ? fl2 : fl4;
  endfunction

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f);
    longint sa, sb, s;
    logic   c, v;
    c  = 1'b0;
    v  = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (alu_op_e'(op))
      ALU_ADD: begin
        r = a + b;
        c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        s = sa + sb;
        v = (s > SMAX) || (s < SMIN);
      end
      ALU_SUB: begin
        r = a - b;
        c = (a < b);
        s = sa - sb;
        v = (s > SMAX) || (s < SMIN);
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = 32'(sa >>> b[4:0]);
      ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      default:  r = 32'd0;
    endcase
    f = {(r == 32'd0), r[31], c, v};
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_valid[u]  = 1'b0;
      m_id[u]     = 0;
      m_res[u]    = '0;
      m_fl[u]     = '0;
      m_rr[u]     = 0;
      m_locked[u] = 1'b0;
      m_owner[u]  = 0;
      acc_g[u]    = -1;
    end
  endfunction

  function automatic int model_grant(input int u);
    int n;
    n = nreq(u);
    if (m_valid[u] && !cons_ready[u]) return -1;
`ifdef ALU_ARB_LOCK_EN
    if (m_locked[u]) return v_valid[u][m_owner[u]] ? m_owner[u] : -1;
`endif
    for (int k = 0; k < n; k++)
      if (v_valid[u][(m_rr[u] + k) % n]) return (m_rr[u] + k) % n;
    return -1;
  endfunction

  function automatic void model_update(input int u, input int g);
    logic [31:0] r;
    logic [3:0]  f;
    if (g >= 0) begin
      ref_alu(v_op[u][g], v_a[u][g], v_b[u][g], r, f);
      m_valid[u] = 1'b1;
      m_id[u]    = g;
      m_res[u]   = r;
      m_fl[u]    = f;
`ifdef ALU_ARB_LOCK_EN
      if (v_lock[u][g]) begin
        m_locked[u] = 1'b1;
        m_owner[u]  = g;
      end else begin
        m_locked[u] = 1'b0;
        m_rr[u]     = (g + 1) % nreq(u);
      end
`else
      m_rr[u] = (g + 1) % nreq(u);
`endif
    end else if (cons_ready[u]) begin
      m_valid[u] = 1'b0;
    end
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    int g [2];
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      g[u] = model_grant(u);
      chk($sformatf("u%0d_req_ready", u), 32'(get_rdy(u)), (g[u] >= 0) ? (32'd1 << g[u]) : 32'd0);
      chk($sformatf("u%0d_resp_valid", u), 32'(get_rv(u)), 32'(m_valid[u]));
      chk($sformatf("u%0d_resp_id", u), 32'(get_id(u)), 32'(m_id[u]));
      chk($sformatf("u%0d_resp_result", u), get_res(u), m_res[u]);
      chk($sformatf("u%0d_resp_flags", u), 32'(get_fl(u)), 32'(m_fl[u]));
    end
    if (rv2 && cons_ready[0]) obs_ids.push_back(int'(id2));
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      model_update(u, g[u]);
      acc_g[u] = g[u];
    end
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_u0_valid", 32'(rv2), 32'd0);
    chk("async_reset_u1_valid", 32'(rv4), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic gen_payload(input int u, input int i, input bit lock_en);
    v_op[u][i]   = 4'($urandom_range(0, 9));
    v_a[u][i]    = pick_operand();
    v_b[u][i]    = pick_operand();
    v_lock[u][i] = lock_en && ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b0;
    for (int u = 0; u < 2; u++) begin
      v_valid[u]    = '0;
      v_lock[u]     = '0;
      cons_ready[u] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        v_op[u][i] = 4'(ALU_ADD);
        v_a[u][i]  = '0;
        v_b[u][i]  = '0;
      end
    end
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_resp_valid", 32'(rv2), 32'd0);
    chk("reset_resp_id", 32'(id2), 32'd0);
    chk("reset_resp_result", res2, 32'd0);
    chk("reset_resp_flags", 32'(fl2), 32'd0);
    chk("reset_u1_result", res4, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ADD 5+7 from requester 0
    v_op[0][0] = 4'(ALU_ADD);
    v_a[0][0]  = 32'd5;
    v_b[0][0]  = 32'd7;
    v_valid[0] = 8'b01;
    tick();
    v_valid[0] = 8'b00;
    chk("add_resp_valid", 32'(rv2), 32'd1);
    chk("add_resp_id", 32'(id2), 32'd0);
    chk("add_resp_result", res2, 32'd12);
    chk("add_resp_flags", 32'(fl2), 32'd0);
    tick();

    // both requesters continuously valid: alternating grants, no bubbles
    obs_ids.delete();
    v_valid[0] = 8'b11;
    gen_payload(0, 0, 1'b0);
    gen_payload(0, 1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (acc_g[0] >= 0) gen_payload(0, acc_g[0], 1'b0);
    end
    v_valid[0] = 8'b00;
    tick();
    chk("alt_result_count", 32'(obs_ids.size()), 32'd8);
    for (int k = 0; k < obs_ids.size(); k++)
      chk($sformatf("alt_id_%0d", k), 32'(obs_ids[k]), 32'((k + 1) % 2));

    // SUB overflow result held under backpressure
    v_op[0][1] = 4'(ALU_SUB);
    v_a[0][1]  = 32'h8000_0000;
    v_b[0][1]  = 32'd1;
    v_lock[0]  = 8'b00;
    v_valid[0] = 8'b10;
    tick();
    v_valid[0]    = 8'b01;
    v_op[0][0]    = 4'(ALU_ADD);
    v_a[0][0]     = 32'd1;
    v_b[0][0]     = 32'd1;
    cons_ready[0] = 1'b0;
    chk("sub_resp_id", 32'(id2), 32'd1);
    chk("sub_resp_result", res2, 32'h7FFF_FFFF);
    chk("sub_flag_overflow", 32'(fl2[0]), 32'd1);
    chk("sub_flag_negative", 32'(fl2[2]), 32'd0);
    repeat (3) tick();
    chk("sub_hold_result", res2, 32'h7FFF_FFFF);
    cons_ready[0] = 1'b1;
    tick();

    // reset while a result is pending; arbitration restarts at requester 0
    v_valid[0]    = 8'b11;
    gen_payload(0, 1, 1'b0);
    cons_ready[0] = 1'b0;
    chk("pre_reset_valid", 32'(rv2), 32'd1);
    do_reset();
    cons_ready[0] = 1'b1;
    tick();
    chk("post_reset_first_id", 32'(id2), 32'd0);
    v_valid[0] = 8'b00;
    tick();

    // requester 0 issues three locked ops and one unlocked op while requester 1 waits
    do_reset();
    obs_ids.delete();
    gen_payload(0, 0, 1'b0);
    gen_payload(0, 1, 1'b0);
    v_lock[0]  = 8'b01;
    v_valid[0] = 8'b11;
    cnt0       = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (acc_g[0] == 0) begin
        cnt0++;
        if (cnt0 < 4) begin
          gen_payload(0, 0, 1'b0);
          v_lock[0][0] = (cnt0 < 3);
        end else begin
          v_valid[0][0] = 1'b0;
        end
      end else if (acc_g[0] == 1) begin
        gen_payload(0, 1, 1'b0);
      end
    end
    v_valid[0] = 8'b00;
    v_lock[0]  = 8'b00;
    tick();
`ifdef ALU_ARB_LOCK_EN
    exp_seq = '{0, 0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    for (int k = 0; k < exp_seq.size(); k++)
      chk($sformatf("lock_seq_id_%0d", k), (k < obs_ids.size()) ? 32'(obs_ids[k]) : 32'hFFFF_FFFF,
          32'(exp_seq[k]));

    // 4-requester instance: only requester 2 valid, second grant must wrap from rr_ptr=3
    do_reset();
    gen_payload(1, 2, 1'b0);
    v_valid[1] = 8'b0100;
    tick();
    gen_payload(1, 2, 1'b0);
    #1;
    chk("wrap_first_id", 32'(id4), 32'd2);
    chk("wrap_grant", 32'(rdy4), 32'b0100);
    tick();
    chk("wrap_second_id", 32'(id4), 32'd2);
    v_valid[1] = 8'b0;
    tick();

    // random traffic on both instances with random consumer backpressure
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int u = 0; u < 2; u++) cons_ready[u] = ($urandom_range(0, 3) != 0);
      tick();
      for (int u = 0; u < 2; u++) begin
        for (int i = 0; i < nreq(u); i++) begin
          if (acc_g[u] == i) begin
            if ($urandom_range(0, 1) == 0) gen_payload(u, i, 1'b1);
            else v_valid[u][i] = 1'b0;
          end else if (!v_valid[u][i] && $urandom_range(0, 2) == 0) begin
            gen_payload(u, i, 1'b1);
            v_valid[u][i] = 1'b1;
          end
        end
      end
    end
    for (int u = 0; u < 2; u++) begin
      v_valid[u]    = '0;
      cons_ready[u] = 1'b1;
    end
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
